// File: rtl/spm_bank_ctrl_pkg.sv
// Shared geometry, stage struct and helpers for the scratchpad bank controller.
package spm_pkg;
  localparam int SPM_NR_WAYS = 4;
  localparam int SPM_LINE_W  = 128;
  localparam int SPM_MEM_W   = 173;
  localparam int SPM_DATA_W  = 64;
  localparam int SPM_IDX_W   = 12;
  localparam int SPM_TID_W   = 4;

  localparam int SPM_WAY_W     = $clog2(SPM_NR_WAYS);
  localparam int SPM_AW        = SPM_IDX_W + SPM_WAY_W;
  localparam int SPM_BOFF_W    = $clog2(SPM_LINE_W / 8);
  localparam int SPM_DOFF_W    = $clog2(SPM_DATA_W / 8);
  localparam int SPM_WOFF_W    = SPM_BOFF_W - SPM_DOFF_W;
  localparam int SPM_ROW_W     = SPM_IDX_W - SPM_BOFF_W;
  localparam int SPM_BE_W      = (SPM_MEM_W + 7) / 8;
  localparam int SPM_DBE_W     = SPM_DATA_W / 8;
  localparam int SPM_LINE_BE_W = SPM_LINE_W / 8;

  // Writes always clear the tag bytes so a line never aliases a cache hit.
  localparam logic [SPM_BE_W-1:0] SPM_TAG_BE_ALL =
    {{(SPM_BE_W - SPM_LINE_BE_W){1'b1}}, {SPM_LINE_BE_W{1'b0}}};

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  err;
    logic [SPM_TID_W-1:0]  tid;
    logic [SPM_WAY_W-1:0]  way;
    logic [SPM_WOFF_W-1:0] woff;
    logic [SPM_DATA_W-1:0] rdata;
  } spm_rsp_stage_t;

  function automatic logic [SPM_DATA_W-1:0] spm_word(logic [SPM_MEM_W-1:0] row,
                                                     logic [SPM_WOFF_W-1:0] woff);
    return row[int'(woff) * SPM_DATA_W +: SPM_DATA_W];
  endfunction
endpackage

// File: rtl/spm_bank_ctrl_if.sv
// Requester-side bus: NR_PORTS parallel request/grant/response channels.
interface spm_bank_ctrl_if import spm_pkg::*; #(
  parameter int NR_PORTS = 2
) ();
  logic [NR_PORTS-1:0]                 req;
  logic [NR_PORTS-1:0]                 we;
  logic [NR_PORTS-1:0][SPM_AW-1:0]     addr;
  logic [NR_PORTS-1:0][SPM_DATA_W-1:0] wdata;
  logic [NR_PORTS-1:0][SPM_DBE_W-1:0]  be;
  logic [NR_PORTS-1:0][SPM_TID_W-1:0]  tid;
  logic [NR_PORTS-1:0]                 gnt;
  logic [NR_PORTS-1:0]                 rvalid;
  logic [NR_PORTS-1:0][SPM_DATA_W-1:0] rdata;
  logic [NR_PORTS-1:0][SPM_TID_W-1:0]  rid;
  logic [NR_PORTS-1:0]                 err;

  modport master (output req, we, addr, wdata, be, tid,
                  input  gnt, rvalid, rdata, rid, err);
  modport slave  (input  req, we, addr, wdata, be, tid,
                  output gnt, rvalid, rdata, rid, err);
endinterface

// File: rtl/spm_way_arbiter.sv
// One-hot arbiter for a single way: starving requesters first, then lowest index.
module spm_way_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] starve,
  output logic [N-1:0] gnt
);
  logic [N-1:0] hot;

  always_comb begin
    hot = req & starve;
    if (hot == '0) hot = req;
    gnt = hot & (~hot + N'(1));
  end
endmodule

// File: rtl/spm_bank_ctrl.sv
// Banked scratchpad controller: per-way arbitration over NR_PORTS requesters,
// SRAM command generation and a LATENCY-deep response pipeline per port.
module spm_bank_ctrl import spm_pkg::*; #(
  parameter int NR_PORTS     = 2,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  spm_bank_ctrl_if.slave                         bus,
  input  logic [SPM_NR_WAYS-1:0]                 active_ways_i,
  output logic [SPM_NR_WAYS-1:0]                 req_o,
  output logic [SPM_NR_WAYS-1:0]                 we_o,
  output logic [SPM_NR_WAYS-1:0][SPM_ROW_W-1:0]  addr_o,
  output logic [SPM_NR_WAYS-1:0][SPM_MEM_W-1:0]  wdata_o,
  output logic [SPM_NR_WAYS-1:0][SPM_BE_W-1:0]   be_o,
  input  logic [SPM_NR_WAYS-1:0][SPM_MEM_W-1:0]  rdata_i
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [NR_PORTS-1:0][SPM_WAY_W-1:0]  pway;
  logic [NR_PORTS-1:0][SPM_WOFF_W-1:0] pwoff;
  logic [NR_PORTS-1:0][SPM_ROW_W-1:0]  prow;
  logic [NR_PORTS-1:0]                 starving, gnt, rv;
  logic [NR_PORTS-1:0][CNT_W-1:0]      starve_cnt;
  logic [SPM_NR_WAYS-1:0][NR_PORTS-1:0] way_req, way_gnt;
  logic [NR_PORTS-1:0][SPM_DATA_W-1:0] cap_data;
  spm_rsp_stage_t [NR_PORTS-1:0][LATENCY-1:0] pipe;
  logic unused_bits;

  always_comb begin
    for (int p = 0; p < NR_PORTS; p++) begin
      pway[p]     = bus.addr[p][SPM_IDX_W +: SPM_WAY_W];
      pwoff[p]    = bus.addr[p][SPM_DOFF_W +: SPM_WOFF_W];
      prow[p]     = bus.addr[p][SPM_BOFF_W +: SPM_ROW_W];
      starving[p] = (starve_cnt[p] == CNT_W'(STARVE_LIMIT));
    end
  end

  always_comb begin
    for (int w = 0; w < SPM_NR_WAYS; w++)
      for (int p = 0; p < NR_PORTS; p++)
        way_req[w][p] = bus.req[p] && !rst_i && (pway[p] == SPM_WAY_W'(w));
  end

  for (genvar w = 0; w < SPM_NR_WAYS; w++) begin : g_arb
    spm_way_arbiter #(.N(NR_PORTS)) u_arb (
      .req    (way_req[w]),
      .starve (starving),
      .gnt    (way_gnt[w])
    );
  end

  always_comb begin
    gnt = '0;
    for (int p = 0; p < NR_PORTS; p++) gnt[p] = way_gnt[pway[p]][p];
  end
  assign bus.gnt = gnt;

  // Disabled ways still grant (so the requester is not stalled) but never touch the SRAM.
  always_comb begin
    req_o   = '0;
    we_o    = '0;
    addr_o  = '0;
    wdata_o = '0;
    be_o    = '0;
    for (int w = 0; w < SPM_NR_WAYS; w++)
      for (int p = 0; p < NR_PORTS; p++)
        if (way_gnt[w][p] && active_ways_i[w]) begin
          req_o[w]  = 1'b1;
          we_o[w]   = bus.we[p];
          addr_o[w] = prow[p];
          if (bus.we[p]) begin
            wdata_o[w] = SPM_MEM_W'({(SPM_LINE_W / SPM_DATA_W){bus.wdata[p]}});
            be_o[w]    = SPM_TAG_BE_ALL |
                         (SPM_BE_W'(bus.be[p]) << (int'(pwoff[p]) * SPM_DBE_W));
          end
        end
  end

  // SRAM data is only valid the cycle after the access, i.e. while the op sits in stage 0.
  always_comb begin
    for (int p = 0; p < NR_PORTS; p++)
      cap_data[p] = (pipe[p][0].err || pipe[p][0].we) ? '0
                  : spm_word(rdata_i[pipe[p][0].way], pipe[p][0].woff);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe       <= '0;
      starve_cnt <= '0;
    end else begin
      for (int p = 0; p < NR_PORTS; p++) begin
        pipe[p][0] <= '{valid: gnt[p], we: bus.we[p], err: !active_ways_i[pway[p]],
                        tid: bus.tid[p], way: pway[p], woff: pwoff[p], rdata: '0};
        for (int s = 1; s < LATENCY; s++) begin
          pipe[p][s] <= pipe[p][s-1];
          if (s == 1) pipe[p][s].rdata <= cap_data[p];
        end
        if (!bus.req[p] || gnt[p])
          starve_cnt[p] <= '0;
        else if (!starving[p])
          starve_cnt[p] <= starve_cnt[p] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NR_PORTS; p++) begin
      rv[p]         = pipe[p][LATENCY-1].valid && !rst_i;
      bus.rvalid[p] = rv[p];
      bus.err[p]    = rv[p] && pipe[p][LATENCY-1].err;
      bus.rid[p]    = pipe[p][LATENCY-1].tid;
      bus.rdata[p]  = (LATENCY == 1) ? cap_data[p] : pipe[p][LATENCY-1].rdata;
    end
  end

  assign unused_bits = ^{rdata_i, pipe, bus.addr};
endmodule

// File: tb/tb_spm_bank_ctrl.sv
// Randomized + directed bench: SRAM model, reference arbitration/memory model, response scoreboard.
module tb_spm_bank_ctrl;
  import spm_pkg::*;

  localparam int NP   = 2;
  localparam int LAT  = 3;
  localparam int LIM  = 4;
  localparam int ROWS = 1 << SPM_ROW_W;

  logic clk = 1'b0;
  logic rst;
  logic [SPM_NR_WAYS-1:0]                active_ways;
  logic [SPM_NR_WAYS-1:0]                req_o, we_o;
  logic [SPM_NR_WAYS-1:0][SPM_ROW_W-1:0] addr_o;
  logic [SPM_NR_WAYS-1:0][SPM_MEM_W-1:0] wdata_o, rdata_i;
  logic [SPM_NR_WAYS-1:0][SPM_BE_W-1:0]  be_o;

  spm_bank_ctrl_if #(.NR_PORTS(NP)) bus ();

  spm_bank_ctrl #(.NR_PORTS(NP), .LATENCY(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .active_ways_i(active_ways),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .be_o(be_o), .rdata_i(rdata_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] init_word(int key);
    return 64'h9E3779B97F4A7C15 * 64'(key + 1);
  endfunction

  // ---------------- SRAM macro model ----------------
  logic [SPM_MEM_W-1:0] mem [SPM_NR_WAYS][ROWS];
  bit mem_ready;
  logic [SPM_NR_WAYS-1:0]                s_req;
  logic [SPM_NR_WAYS-1:0][SPM_ROW_W-1:0] s_addr;
  logic [SPM_NR_WAYS-1:0][SPM_MEM_W-1:0] s_wdata;
  logic [SPM_NR_WAYS-1:0][SPM_BE_W-1:0]  s_be;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int w = 0; w < SPM_NR_WAYS; w++)
        for (int r = 0; r < ROWS; r++)
          mem[w][r] <= {45'(init_word(100000 + w*512 + r)),
                        init_word(w*512 + r*2 + 1), init_word(w*512 + r*2)};
      rdata_i   <= '0;
      mem_ready <= 1'b1;
    end else begin
      for (int w = 0; w < SPM_NR_WAYS; w++)
        if (s_req[w]) begin
          for (int i = 0; i < SPM_MEM_W; i++)
            if (s_be[w][i/8]) mem[w][s_addr[w]][i] <= s_wdata[w][i];
          rdata_i[w] <= mem[w][s_addr[w]];
        end
    end
  end

  // ---------------- reference model + scoreboard push ----------------
  typedef struct {
    int          due;
    logic [3:0]  tid;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q [NP][$];
  int          cnt [NP];
  logic [63:0] ref_mem [int];

  function automatic int way_of(logic [SPM_AW-1:0] a);  return int'(a) / 4096;     endfunction
  function automatic int row_of(logic [SPM_AW-1:0] a);  return (int'(a) / 16) % 256; endfunction
  function automatic int woff_of(logic [SPM_AW-1:0] a); return (int'(a) / 8) % 2;    endfunction

  task automatic model_cycle();
    logic [NP-1:0] eg   = '0;
    logic [3:0]    ereq = '0;
    logic [3:0]    ewe  = '0;
    int            win_of [SPM_NR_WAYS];
    for (int w = 0; w < SPM_NR_WAYS; w++) begin
      int win = -1;
      for (int p = 0; p < NP; p++)
        if (bus.req[p] && way_of(bus.addr[p]) == w && cnt[p] == LIM && win < 0) win = p;
      for (int p = 0; p < NP; p++)
        if (bus.req[p] && way_of(bus.addr[p]) == w && win < 0) win = p;
      win_of[w] = win;
      if (win >= 0) begin
        eg[win] = 1'b1;
        if (active_ways[w]) begin
          ereq[w] = 1'b1;
          ewe[w]  = bus.we[win];
        end
      end
    end
    check("gnt", bus.gnt, eg);
    check("req_o", req_o, ereq);
    check("we_o", we_o, ewe);
    for (int w = 0; w < SPM_NR_WAYS; w++) begin
      logic [SPM_BE_W-1:0] ebe = '0;
      if (ereq[w] && ewe[w]) begin
        int p = win_of[w];
        for (int b = 0; b < SPM_BE_W; b++)
          ebe[b] = (b >= 16) || ((b / 8 == woff_of(bus.addr[p])) && bus.be[p][b % 8]);
      end
      check("be_o", be_o[w], ebe);
      if (ereq[w]) check("addr_o", addr_o[w], row_of(bus.addr[win_of[w]]));
    end
    for (int p = 0; p < NP; p++) begin
      if (eg[p]) begin
        int    w   = way_of(bus.addr[p]);
        int    key = w*512 + row_of(bus.addr[p])*2 + woff_of(bus.addr[p]);
        logic [63:0] cur = ref_mem.exists(key) ? ref_mem[key] : init_word(key);
        if (!active_ways[w]) begin
          exp_q[p].push_back('{due: cyc + LAT, tid: bus.tid[p], data: 64'h0, err: 1'b1});
        end else if (bus.we[p]) begin
          check("wdata_tag", wdata_o[w][SPM_MEM_W-1:SPM_LINE_W], 0);
          check("wdata_slot", wdata_o[w][woff_of(bus.addr[p])*64 +: 64], bus.wdata[p]);
          for (int b = 0; b < 8; b++)
            if (bus.be[p][b]) cur[b*8 +: 8] = bus.wdata[p][b*8 +: 8];
          ref_mem[key] = cur;
          exp_q[p].push_back('{due: cyc + LAT, tid: bus.tid[p], data: 64'h0, err: 1'b0});
        end else begin
          exp_q[p].push_back('{due: cyc + LAT, tid: bus.tid[p], data: cur, err: 1'b0});
        end
      end
      if (!bus.req[p] || eg[p]) cnt[p] = 0;
      else if (cnt[p] < LIM)    cnt[p] = cnt[p] + 1;
    end
  endtask

  always @(negedge clk) begin
    s_req   <= req_o;
    s_addr  <= addr_o;
    s_wdata <= wdata_o;
    s_be    <= be_o;
    if (rst) begin
      check("rst_gnt", bus.gnt, 0);
      check("rst_req_o", req_o, 0);
      check("rst_be_o", be_o, 0);
      for (int p = 0; p < NP; p++) begin
        exp_q[p].delete();
        cnt[p] = 0;
      end
    end else begin
      model_cycle();
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      if (rst) begin
        check("rst_rvalid", bus.rvalid[p], 0);
      end else if (bus.rvalid[p]) begin
        if (exp_q[p].size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_rvalid port %0d: got rvalid=1 want 0 (cycle %0d)", p, cyc);
        end else begin
          e = exp_q[p].pop_front();
          check("rsp_cycle", cyc, e.due);
          check("rid", bus.rid[p], e.tid);
          check("err", bus.err[p], e.err);
          check("rdata", bus.rdata[p], e.data);
        end
      end else if (exp_q[p].size() > 0 && exp_q[p][0].due <= cyc) begin
        total++; bad++;
        $display("FAIL missing_rvalid port %0d: got rvalid=0 want 1 tid=%0d (cycle %0d)",
                 p, exp_q[p][0].tid, cyc);
        void'(exp_q[p].pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_port(int p, logic r, logic w, logic [SPM_AW-1:0] a,
                          logic [63:0] d, logic [7:0] be, logic [3:0] t);
    bus.req[p] = r; bus.we[p] = w; bus.addr[p] = a;
    bus.wdata[p] = d; bus.be[p] = be; bus.tid[p] = t;
  endtask

  task automatic idle(int n);
    bus.req = '0;
    repeat (n) step();
  endtask

  task automatic hammer(int n, output int first1);
    first1 = 0;
    set_port(0, 1'b1, 1'b0, 14'h1040, 64'h0, 8'h00, 4'd7);
    set_port(1, 1'b1, 1'b0, 14'h1058, 64'h0, 8'h00, 4'd9);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.gnt[1] && first1 == 0) first1 = i;
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_port(int p);
    logic [SPM_AW-1:0] a;
    a = SPM_AW'($urandom_range(0, 3) * 4096 + $urandom_range(0, 7) * 16 + $urandom_range(0, 15));
    set_port(p, $urandom_range(0, 99) < 85, 1'($urandom), a,
             {$urandom, $urandom}, 8'($urandom), 4'($urandom));
  endtask

  initial begin
    int f;
    logic [NP-1:0] g;
    rst = 1'b1;
    active_ways = 4'hF;
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, '0, '0, '0, '0);
    repeat (3) step();
    rst = 1'b0;
    step();

    // disjoint ways in the same cycle
    set_port(0, 1'b1, 1'b0, 14'h0020, 64'h0, 8'h00, 4'd3);
    set_port(1, 1'b1, 1'b1, 14'h2038, 64'hA5A5_5A5A_1234_5678, 8'hF0, 4'd6);
    step();
    idle(LAT + 2);

    // conflict on way 1: port 1 must win on its 5th cycle
    hammer(8, f);
    check("starve_first_grant", f, 5);
    idle(LAT + 2);

    // write then read back, plus the other word of the row
    set_port(0, 1'b1, 1'b1, 14'h0010, 64'hDEADBEEF_01234567, 8'hFF, 4'd1);
    step();
    set_port(0, 1'b1, 1'b0, 14'h0010, 64'h0, 8'h00, 4'd2);
    step();
    set_port(0, 1'b1, 1'b0, 14'h0018, 64'h0, 8'h00, 4'd3);
    step();
    idle(LAT + 2);

    // disabled way
    active_ways = 4'b0111;
    set_port(0, 1'b1, 1'b0, 14'h3000, 64'h0, 8'h00, 4'd5);
    set_port(1, 1'b1, 1'b1, 14'h3028, 64'h1111_2222_3333_4444, 8'h0F, 4'd8);
    step();
    bus.req = '0;
    active_ways = 4'hF;
    idle(LAT + 2);

    // back-to-back reads through the pipeline
    for (int i = 1; i <= 4; i++) begin
      set_port(1, 1'b1, 1'b0, SPM_AW'(16'h2000 + i * 24), 64'h0, 8'h00, 4'(i));
      step();
    end
    idle(LAT + 2);

    // reset mid-flight while port 1 is part-way to starving
    hammer(3, f);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    hammer(8, f);
    check("starve_after_reset", f, 5);
    idle(LAT + 2);

    // randomized traffic, requests held until granted
    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 40) active_ways = 4'($urandom_range(0, 15));
      if (i % 80 == 0)  active_ways = 4'hF;
      @(negedge clk);
      g = bus.gnt;
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++)
        if (!bus.req[p] || g[p]) rand_port(p);
    end
    idle(LAT + 3);
    check("drain_empty", exp_q[0].size() + exp_q[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
